operand_fetch: RTL

Decode-to-execute stage that drives the register file's two combinational read ports and registers the operands for execute. It keeps a per-register busy scoreboard, so it stalls on RAW and WAW hazards until writeback retires the pending write. It bypasses same-cycle writeback data, because the register file write lands only at the next clock edge. Both sides use a valid/ready handshake.

---
 rtl/tinycpu_pkg.sv | 19 +
 rtl/operand_fetch_if.sv | 41 ++++
 rtl/operand_scoreboard.sv | 35 +++
 rtl/operand_fetch.sv | 72 +++++++
 4 files changed

// File: rtl/tinycpu_pkg.sv
// Shared widths and the issued-instruction bundle for the operand fetch stage.
package tinycpu_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;
    localparam int OP_WIDTH       = 6;

    typedef logic [DATA_WIDTH-1:0]     data_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_t;
    typedef logic [OP_WIDTH-1:0]       op_t;

    typedef struct packed {
        op_t   op;
        reg_t  rd;
        logic  rd_we;
        data_t a;
        data_t b;
    } issued_t;
endpackage

// File: rtl/operand_fetch_if.sv
// Decode, register-file, writeback and execute signals of the operand fetch stage.
interface operand_fetch_if;
    import tinycpu_pkg::*;

    logic  in_valid;
    logic  in_ready;
    op_t   in_op;
    reg_t  in_rs0;
    reg_t  in_rs1;
    reg_t  in_rd;
    logic  in_rd_we;
    reg_t  rf_read_address_0;
    reg_t  rf_read_address_1;
    data_t rf_read_data_0;
    data_t rf_read_data_1;
    logic  wb_valid;
    reg_t  wb_addr;
    data_t wb_data;
    logic  out_valid;
    logic  out_ready;
    op_t   out_op;
    reg_t  out_rd;
    logic  out_rd_we;
    data_t out_a;
    data_t out_b;
    logic  stall;

    modport master (
        output in_valid, in_op, in_rs0, in_rs1, in_rd, in_rd_we,
        output rf_read_data_0, rf_read_data_1, wb_valid, wb_addr, wb_data, out_ready,
        input  in_ready, rf_read_address_0, rf_read_address_1,
        input  out_valid, out_op, out_rd, out_rd_we, out_a, out_b, stall
    );

    modport slave (
        input  in_valid, in_op, in_rs0, in_rs1, in_rd, in_rd_we,
        input  rf_read_data_0, rf_read_data_1, wb_valid, wb_addr, wb_data, out_ready,
        output in_ready, rf_read_address_0, rf_read_address_1,
        output out_valid, out_op, out_rd, out_rd_we, out_a, out_b, stall
    );
endinterface

// File: rtl/operand_scoreboard.sv
// Per-register busy bits: set by an issuing writer, cleared by writeback.
module operand_scoreboard
    import tinycpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic set_i,
    input  reg_t set_addr_i,
    input  logic clr_i,
    input  reg_t clr_addr_i,
    input  reg_t rs0_i,
    input  reg_t rs1_i,
    input  reg_t rd_i,
    output logic busy_rs0_o,
    output logic busy_rs1_o,
    output logic busy_rd_o
);
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Set applied after clear so a new writer keeps rd busy across its predecessor's writeback.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_addr_i] = 1'b0;
        if (set_i) busy_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_rs0_o = busy_q[rs0_i];
    assign busy_rs1_o = busy_q[rs1_i];
    assign busy_rd_o  = busy_q[rd_i];
endmodule

// File: rtl/operand_fetch.sv
// Reads operands, stalls on RAW/WAW against the busy scoreboard, bypasses same-cycle writeback.
module operand_fetch
    import tinycpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);
    logic    busy_rs0, busy_rs1, busy_rd;
    logic    wb_hit_0, wb_hit_1, wb_hit_rd;
    logic    hazard, slot_free, ready, issue;
    logic    out_valid_q;
    issued_t out_q, out_d;

    operand_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_i      (issue && bus.in_rd_we),
        .set_addr_i (bus.in_rd),
        .clr_i      (bus.wb_valid),
        .clr_addr_i (bus.wb_addr),
        .rs0_i      (bus.in_rs0),
        .rs1_i      (bus.in_rs1),
        .rd_i       (bus.in_rd),
        .busy_rs0_o (busy_rs0),
        .busy_rs1_o (busy_rs1),
        .busy_rd_o  (busy_rd)
    );

    // The register file write lands at the edge, so a retiring write is consumed from wb_data.
    assign wb_hit_0  = bus.wb_valid && (bus.wb_addr == bus.in_rs0);
    assign wb_hit_1  = bus.wb_valid && (bus.wb_addr == bus.in_rs1);
    assign wb_hit_rd = bus.wb_valid && (bus.wb_addr == bus.in_rd);

    assign hazard    = (busy_rs0 && !wb_hit_0) || (busy_rs1 && !wb_hit_1) ||
                       (bus.in_rd_we && busy_rd && !wb_hit_rd);
    assign slot_free = !out_valid_q || bus.out_ready;
    assign ready     = !hazard && slot_free;
    assign issue     = bus.in_valid && ready;

    assign bus.in_ready          = ready;
    assign bus.stall             = bus.in_valid && hazard;
    assign bus.rf_read_address_0 = bus.in_rs0;
    assign bus.rf_read_address_1 = bus.in_rs1;

    always_comb begin
        out_d.op    = bus.in_op;
        out_d.rd    = bus.in_rd;
        out_d.rd_we = bus.in_rd_we;
        out_d.a     = wb_hit_0 ? bus.wb_data : bus.rf_read_data_0;
        out_d.b     = wb_hit_1 ? bus.wb_data : bus.rf_read_data_1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (issue) begin
            out_valid_q <= 1'b1;
            out_q       <= out_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_q.op;
    assign bus.out_rd    = out_q.rd;
    assign bus.out_rd_we = out_q.rd_we;
    assign bus.out_a     = out_q.a;
    assign bus.out_b     = out_q.b;
endmodule
